// File: rtl/gridx_mem_pkg.sv
// rtl/gridx_mem_pkg.sv - shared types for the sram bank request front-end
package gridx_mem_pkg;

    localparam int TAG_ID_BITS = 8;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        GATED  = 2'd1,
        WAKE   = 2'd2
    } power_state_e;

    typedef struct packed {
        logic                   valid;
        logic [TAG_ID_BITS-1:0] id;
    } resp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; priority starts at the pointer and
// the pointer moves past the winner on each accepted grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [ID_W-1:0] r_ptr;
    logic            w_found;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[ID_W'(idx)]) begin
                w_found              = 1'b1;
                o_grant[ID_W'(idx)]  = 1'b1;
                o_grant_id           = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// rtl/sram_bank_arbiter.sv - arbitrates NUM_REQ requesters onto one bank's read
// and write ports, routes responses back, and power-gates the bank when idle
module sram_bank_arbiter
    import gridx_mem_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BANK_DEPTH  = 256,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_BITS   = $clog2(BANK_DEPTH),
    parameter int IDLE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic [NUM_REQ-1:0]            wack,
    output logic                          bank_enable,
    output logic                          bank_read_valid,
    output logic [ADDR_BITS-1:0]          bank_read_address,
    output logic                          bank_write_valid,
    output logic [ADDR_BITS-1:0]          bank_write_address,
    output logic [DATA_WIDTH-1:0]         bank_write_data,
    input  logic                          bank_read_ready,
    input  logic [DATA_WIDTH-1:0]         bank_read_data,
    input  logic                          bank_write_ready
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

    power_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
    resp_tag_t        r_rd_tag, r_wr_tag;

    logic [NUM_REQ-1:0] w_rd_grant, w_wr_grant;
    logic [ID_W-1:0]    w_rd_gid, w_wr_gid;
    logic               w_active, w_rd_any, w_wr_any, w_idle;

    assign w_active = (r_state == ACTIVE) && !reset;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req_valid & ~req_we),
        .i_advance  (w_active),
        .o_grant    (w_rd_grant),
        .o_grant_id (w_rd_gid)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req_valid & req_we),
        .i_advance  (w_active),
        .o_grant    (w_wr_grant),
        .o_grant_id (w_wr_gid)
    );

    assign w_rd_any         = w_active && (|w_rd_grant);
    assign w_wr_any         = w_active && (|w_wr_grant);
    assign req_ready        = w_active ? (w_rd_grant | w_wr_grant) : '0;
    assign bank_read_valid  = w_rd_any;
    assign bank_write_valid = w_wr_any;
    assign resp_rdata       = bank_read_data;

    always_comb begin
        bank_read_address  = '0;
        bank_write_address = '0;
        bank_write_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rd_gid == ID_W'(i)) begin
                bank_read_address = req_address[i*ADDR_BITS +: ADDR_BITS];
            end
            if (w_wr_gid == ID_W'(i)) begin
                bank_write_address = req_address[i*ADDR_BITS +: ADDR_BITS];
                bank_write_data    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The bank answers one cycle after the grant, so the tag remembers who asked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_tag <= '0;
            r_wr_tag <= '0;
        end else begin
            r_rd_tag <= '{valid: w_rd_any, id: TAG_ID_BITS'(w_rd_gid)};
            r_wr_tag <= '{valid: w_wr_any, id: TAG_ID_BITS'(w_wr_gid)};
        end
    end

    always_comb begin
        resp_valid = '0;
        wack       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset && r_rd_tag.valid && bank_read_ready && r_rd_tag.id == TAG_ID_BITS'(i)) begin
                resp_valid[i] = 1'b1;
            end
            if (!reset && r_wr_tag.valid && bank_write_ready && r_wr_tag.id == TAG_ID_BITS'(i)) begin
                wack[i] = 1'b1;
            end
        end
    end

    assign w_idle = (req_valid == '0) && !r_rd_tag.valid && !r_wr_tag.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ACTIVE;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        bank_enable    = 1'b1;
        case (r_state)
            ACTIVE: begin
                if (!w_idle) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == CNT_MAX) begin
                    if (IDLE_CYCLES != 0) begin
                        w_state_nxt = GATED;
                    end
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            GATED: begin
                bank_enable    = 1'b0;
                w_idle_cnt_nxt = '0;
                if (|req_valid) begin
                    w_state_nxt = WAKE;
                end
            end
            WAKE: begin
                w_idle_cnt_nxt = '0;
                w_state_nxt    = ACTIVE;
            end
            default: begin
                w_idle_cnt_nxt = '0;
                w_state_nxt    = ACTIVE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb/tb_sram_bank_arbiter.sv - self-checking bench for sram_bank_arbiter
module tb_sram_bank_arbiter;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int AB   = 8;
    localparam int IDLE = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_we;
    logic [N*AB-1:0] req_address;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, resp_valid, wack;
    logic [DW-1:0]   resp_rdata;
    logic            bank_enable, bank_read_valid, bank_write_valid;
    logic [AB-1:0]   bank_read_address, bank_write_address;
    logic [DW-1:0]   bank_write_data, bank_read_data;
    logic            bank_read_ready, bank_write_ready;

    logic [N-1:0]    z_req_ready, z_resp_valid, z_wack;
    logic [DW-1:0]   z_resp_rdata, z_bank_write_data;
    logic            z_bank_enable, z_bank_read_valid, z_bank_write_valid;
    logic [AB-1:0]   z_bank_read_address, z_bank_write_address;

    sram_bank_arbiter #(.NUM_REQ(N), .BANK_DEPTH(256), .DATA_WIDTH(DW), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_address(req_address), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wack(wack),
        .bank_enable(bank_enable), .bank_read_valid(bank_read_valid),
        .bank_read_address(bank_read_address), .bank_write_valid(bank_write_valid),
        .bank_write_address(bank_write_address), .bank_write_data(bank_write_data),
        .bank_read_ready(bank_read_ready), .bank_read_data(bank_read_data),
        .bank_write_ready(bank_write_ready)
    );

    sram_bank_arbiter #(.NUM_REQ(N), .BANK_DEPTH(256), .DATA_WIDTH(DW), .IDLE_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_address(req_address), .req_wdata(req_wdata), .req_ready(z_req_ready),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .wack(z_wack),
        .bank_enable(z_bank_enable), .bank_read_valid(z_bank_read_valid),
        .bank_read_address(z_bank_read_address), .bank_write_valid(z_bank_write_valid),
        .bank_write_address(z_bank_write_address), .bank_write_data(z_bank_write_data),
        .bank_read_ready(1'b1), .bank_read_data('0), .bank_write_ready(1'b1)
    );

    function automatic logic [DW-1:0] init_val(int a);
        if (a < 8)   return 64'h1000 + 64'(a);
        if (a >= 16) return 64'h2000 + 64'(a);
        return '0;
    endfunction

    logic [DW-1:0] mem [256];
    initial for (int a = 0; a < 256; a++) mem[a] = init_val(a);

    // Bank stand-in: registered read, reads before writes on the same edge.
    always @(posedge clk) begin
        if (bank_read_valid)  bank_read_data <= mem[bank_read_address];
        if (bank_write_valid) mem[bank_write_address] <= bank_write_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        if (!reset) chk("dut0_enable", 64'(z_bank_enable), 64'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic int pick(int ptr, logic [N-1:0] m);
        int best, bd;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (m[i] && ((i - ptr + N) % N) < bd) begin
                bd   = (i - ptr + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] oh(int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] we;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_resp;
        logic [N-1:0] exp_wack;
    } vec_t;

    vec_t tbl [11];

    int m_rptr, m_wptr, m_state, m_idle, m_rtag, m_wtag, quiet;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] mmem [256];
    bit            p_v [N];
    bit            p_we [N];
    logic [AB-1:0] p_a [N];
    logic [DW-1:0] p_d [N];

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010, 4'b0000};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100, 4'b0000};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[5]  = '{4'b1000, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[7]  = '{4'b1001, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
        tbl[8]  = '{4'b0110, 4'b0010, 4'b0110, 4'b1000, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        req_we           = '0;
        bank_read_ready  = 1'b1;
        bank_write_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_address[i*AB +: AB] = AB'(4 + i);
            req_wdata[i*DW +: DW]   = 64'hAA00 + 64'(i);
        end

        reset     = 1'b1;
        req_valid = '0;
        next_cycle();
        wait_neg();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp", 64'(resp_valid), 64'd0);
        chk("rst_wack", 64'(wack), 64'd0);
        chk("rst_enable", 64'(bank_enable), 64'd1);
        chk("rst_bank_valid", 64'({bank_read_valid, bank_write_valid}), 64'd0);
        do_reset();

        // Round-robin order, pointer wrap, and a read/write pair in one cycle.
        for (int s = 0; s < 11; s++) begin
            req_valid = tbl[s].valid;
            req_we    = tbl[s].we;
            wait_neg();
            chk($sformatf("tbl%0d_ready", s), 64'(req_ready), 64'(tbl[s].exp_ready));
            chk($sformatf("tbl%0d_resp", s), 64'(resp_valid), 64'(tbl[s].exp_resp));
            chk($sformatf("tbl%0d_wack", s), 64'(wack), 64'(tbl[s].exp_wack));
            for (int i = 0; i < N; i++)
                if (tbl[s].exp_resp[i]) chk($sformatf("tbl%0d_rdata", s), resp_rdata, 64'h1004 + 64'(i));
            next_cycle();
        end

        req_address[1*AB +: AB] = 8'd9;
        req_address[2*AB +: AB] = 8'd9;
        req_wdata[1*DW +: DW]   = 64'hDEAD;
        req_valid = 4'b0110;
        req_we    = 4'b0010;
        wait_neg();
        chk("same_addr_ready", 64'(req_ready), 64'b0110);
        next_cycle();
        req_valid = '0;
        req_we    = '0;
        wait_neg();
        chk("same_addr_resp", 64'(resp_valid), 64'b0100);
        chk("same_addr_old", resp_rdata, 64'd0);
        chk("same_addr_wack", 64'(wack), 64'b0010);
        next_cycle();
        req_valid = 4'b0100;
        wait_neg();
        chk("reread_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        req_valid = '0;
        wait_neg();
        chk("reread_resp", 64'(resp_valid), 64'b0100);
        chk("reread_data", resp_rdata, 64'hDEAD);
        next_cycle();

        // Reset lands in the cycle the response would have appeared.
        req_valid = 4'b0001;
        wait_neg();
        chk("mid_ready", 64'(req_ready), 64'b0001);
        next_cycle();
        reset     = 1'b1;
        req_valid = '0;
        wait_neg();
        chk("mid_resp_in_reset", 64'(resp_valid), 64'd0);
        chk("mid_ready_in_reset", 64'(req_ready), 64'd0);
        chk("mid_bank_valid", 64'({bank_read_valid, bank_write_valid}), 64'd0);
        next_cycle();
        reset = 1'b0;
        wait_neg();
        chk("mid_resp_after", 64'(resp_valid), 64'd0);
        chk("mid_wack_after", 64'(wack), 64'd0);
        chk("mid_enable_after", 64'(bank_enable), 64'd1);
        next_cycle();

        do_reset();
        for (int c = 0; c < 5; c++) begin
            wait_neg();
            chk($sformatf("gate_enable_c%0d", c), 64'(bank_enable), (c < IDLE) ? 64'd1 : 64'd0);
            next_cycle();
        end
        req_valid = 4'b0001;
        req_we    = '0;
        wait_neg();
        chk("wake_x_ready", 64'(req_ready), 64'd0);
        chk("wake_x_enable", 64'(bank_enable), 64'd0);
        next_cycle();
        wait_neg();
        chk("wake_x1_ready", 64'(req_ready), 64'd0);
        chk("wake_x1_enable", 64'(bank_enable), 64'd1);
        next_cycle();
        wait_neg();
        chk("wake_x2_ready", 64'(req_ready), 64'b0001);
        next_cycle();
        req_valid = '0;
        wait_neg();
        chk("wake_x3_resp", 64'(resp_valid), 64'b0001);
        chk("wake_x3_data", resp_rdata, 64'h1004);
        next_cycle();

        // Random traffic against a spec-level model of arbitration, memory and power.
        do_reset();
        m_rptr = 0; m_wptr = 0; m_state = 0; m_idle = 0; m_rtag = -1; m_wtag = -1; quiet = 0;
        for (int a = 0; a < 256; a++) mmem[a] = init_val(a);
        for (int i = 0; i < N; i++) p_v[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int gr, gw;
            bit act, idle;
            logic [N-1:0] rmask, wmask, exp_resp, exp_wack;
            for (int i = 0; i < N; i++) begin
                if (!p_v[i] && quiet == 0 && $urandom_range(0, 1) == 1) begin
                    p_v[i]  = 1;
                    p_we[i] = 1'($urandom_range(0, 1));
                    p_a[i]  = AB'(16 + $urandom_range(0, 15));
                    p_d[i]  = {$urandom, $urandom};
                end
                req_valid[i]            = p_v[i];
                req_we[i]               = p_we[i];
                req_address[i*AB +: AB] = p_a[i];
                req_wdata[i*DW +: DW]   = p_d[i];
            end
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 49) == 0) quiet = $urandom_range(4, 12);
            bank_read_ready  = ($urandom_range(0, 9) != 0);
            bank_write_ready = ($urandom_range(0, 9) != 0);
            wait_neg();
            for (int i = 0; i < N; i++) begin
                rmask[i] = p_v[i] && !p_we[i];
                wmask[i] = p_v[i] && p_we[i];
            end
            act = (m_state == 0);
            gr  = act ? pick(m_rptr, rmask) : -1;
            gw  = act ? pick(m_wptr, wmask) : -1;
            exp_resp = (bank_read_ready  && m_rtag >= 0) ? oh(m_rtag) : '0;
            exp_wack = (bank_write_ready && m_wtag >= 0) ? oh(m_wtag) : '0;
            chk("rnd_ready", 64'(req_ready), 64'(oh(gr) | oh(gw)));
            chk("rnd_resp", 64'(resp_valid), 64'(exp_resp));
            chk("rnd_wack", 64'(wack), 64'(exp_wack));
            chk("rnd_enable", 64'(bank_enable), (m_state != 1) ? 64'd1 : 64'd0);
            if (exp_resp != 0) chk("rnd_rdata", resp_rdata, m_rdata);
            idle = (req_valid == 0) && m_rtag < 0 && m_wtag < 0;
            m_rtag = gr;
            if (gr >= 0) begin
                m_rdata = mmem[p_a[gr]];
                m_rptr  = (gr + 1) % N;
                p_v[gr] = 0;
            end
            m_wtag = gw;
            if (gw >= 0) begin
                mmem[p_a[gw]] = p_d[gw];
                m_wptr  = (gw + 1) % N;
                p_v[gw] = 0;
            end
            case (m_state)
                0: begin
                    if (!idle) m_idle = 0;
                    else if (m_idle == IDLE - 1) m_state = 1;
                    else m_idle++;
                end
                1: if (req_valid != 0) m_state = 2;
                default: begin
                    m_state = 0;
                    m_idle  = 0;
                end
            endcase
            next_cycle();
        end

        req_valid        = '0;
        bank_read_ready  = 1'b1;
        bank_write_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            wait_neg();
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Request front-end for one `sram_bank`. It accepts memory requests from `NUM_REQ` requesters (LSUs or DMA) and arbitrates them onto the bank's single read port and single write port. Read and write traffic each use an independent round-robin arbiter. Each one-cycle bank response is routed back to the requester that issued it. An idle-timeout FSM drives the bank `enable` line for power gating and handles the wake-up cycle.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, at least 2.
- `BANK_DEPTH`, 256: rows in the attached bank.
- `DATA_WIDTH`, 64: bits per row.
- `ADDR_BITS`, `$clog2(BANK_DEPTH)`: row address width.
- `IDLE_CYCLES`, 16: consecutive idle cycles before gating. 0 disables gating.

Ports. One clock; reset is synchronous and active-high.
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `req_valid` input, NUM_REQ: request present, one bit per requester.
- `req_we` input, NUM_REQ: 1 = write, 0 = read.
- `req_address` input, NUM_REQ*ADDR_BITS: requester i uses slice [i*ADDR_BITS +: ADDR_BITS].
- `req_wdata` input, NUM_REQ*DATA_WIDTH: write data, sliced the same way as `req_address`.
- `req_ready` output, NUM_REQ: request accepted this cycle.
- `resp_valid` output, NUM_REQ: read data valid, one-cycle pulse.
- `resp_rdata` output, DATA_WIDTH: read data, shared by all requesters and qualified by `resp_valid`.
- `wack` output, NUM_REQ: write completed, one-cycle pulse.
- `bank_enable` output, 1: connects to the bank's `enable`.
- `bank_read_valid`, `bank_read_address`, `bank_write_valid`, `bank_write_address`, `bank_write_data` outputs: drive the bank ports of the same names.
- `bank_read_ready` input, 1: from the bank.
- `bank_read_data` input, DATA_WIDTH: from the bank.
- `bank_write_ready` input, 1: from the bank.

## Operation
Arbitration:
- The read channel considers requesters with `req_valid & ~req_we`. The write channel considers `req_valid & req_we`.
- Each channel grants at most one requester per cycle. Priority starts at that channel's pointer `ptr` and rises modulo NUM_REQ.
- On a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. The pointer holds when there is no grant.
- `req_ready[i]` = granted & `power_state == ACTIVE`. It is combinational.
- The granted address and data are muxed combinationally onto the bank ports. `bank_*_valid` = (any grant) & ACTIVE.

Response routing:
- A registered tag per channel stores `{valid, id}` of the grant.
- `resp_valid[id]` = `rd_tag.valid & bank_read_ready`. `resp_rdata` = `bank_read_data`.
- `wack[id]` = `wr_tag.valid & bank_write_ready`.

Same-cycle read and write to the same address:
- The read returns the old data, because the bank reads before it writes. Requesters must order dependent accesses themselves.

Power FSM (states ACTIVE, GATED, WAKE):
- ACTIVE: `bank_enable`=1. `idle_cnt` increments on each cycle with `req_valid`==0 and no tag valid, and clears otherwise. When `IDLE_CYCLES`≠0 and `idle_cnt` reaches `IDLE_CYCLES-1` on an idle cycle, go to GATED.
- GATED: `bank_enable`=0 and all `req_ready`=0. Any `req_valid` bit moves to WAKE.
- WAKE: `bank_enable`=1 and `req_ready`=0 for exactly one cycle, then go to ACTIVE with `idle_cnt`=0.

## Timing
Reset values:
- `power_state`=ACTIVE, `bank_enable`=1.
- Both pointers 0, both tags invalid, `idle_cnt`=0.
- While `reset` is high: all `req_ready`, `resp_valid`, `wack` and `bank_*_valid` = 0.

Latency:
- A request accepted at edge T returns `resp_valid` or `wack` during cycle T+1, high for exactly 1 cycle.
- Throughput is 1 read plus 1 write per cycle.
- Wake penalty: a request arriving while GATED is accepted 2 cycles later (GATED, then WAKE, then ACTIVE grant).

Handshake and boundary rules:
- A requester holds `req_valid`, address and data stable until `req_ready`. A request is never dropped.
- Reset during an in-flight access clears the tags. No `resp_valid` or `wack` follows.
- The pointer wraps from NUM_REQ-1 to 0.
- `idle_cnt` saturates at `IDLE_CYCLES-1` and never wraps.

## Structure
- Package `gridx_mem_pkg` holds the `power_state_e` enum (ACTIVE, GATED, WAKE) and the `resp_tag_t` struct `{valid, id}`.
- Sub-module `rr_arbiter`, parameterized by NUM_REQ, is instantiated once per channel. Its ports are request vector, advance strobe, one-hot grant and grant id. It owns its pointer.

## Test plan
- **Read arbitration:** reset, then requesters 0–3 all read addresses 4,5,6,7 continuously. Required: grants occur in order 0,1,2,3,0; each `resp_valid[i]` pulses one cycle after its `req_ready[i]` with that address's data.
- **Parallel write and read:** requester 1 writes 0xDEAD to addr 9 while requester 2 reads addr 9 in the same cycle. Required: both are accepted; `resp_rdata` = old value 0; a later read returns 0xDEAD; `wack[1]` pulses at T+1.
- **Pointer wrap:** only requester 3 requests, then requesters 0 and 3 request together. Required: after the grant to 3 the pointer is 0, so requester 0 is granted first.
- **Gating:** `IDLE_CYCLES`=4 with no requests. Required: `bank_enable` drops after 4 idle cycles; a read at cycle X gets `req_ready` at X+2 and data at X+3.
- **Reset mid-flight:** assert `reset` in the cycle after a read grant. Required: no `resp_valid`; all outputs take their reset values.
- **Gating disabled:** `IDLE_CYCLES`=0 and 1000 idle cycles. Required: `bank_enable` stays 1 throughout.
